// File: rtl/uart_rx_frame_unpacker_if.sv
// Frame-capture inputs and byte-stream outputs of uart_rx_frame_unpacker.
// master = the unpacker itself; slave = the receiver/consumer side.
interface uart_rx_frame_unpacker_if #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = 255,
  parameter int DATA_BYTES   = $clog2(MAX_MSG_LEN),
  parameter int IN_DATA_SIZE = DATA_BYTES * BYTE_SIZE,
  parameter int DROP_CNT_W   = 8
);
  logic [BYTE_SIZE-1:0]    i_opt;
  logic [BYTE_SIZE-1:0]    i_len;
  logic [IN_DATA_SIZE-1:0] i_data;
  logic                    i_valid;
  logic [BYTE_SIZE-1:0]    m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_first;
  logic                    m_last;
  logic [BYTE_SIZE-1:0]    m_opt;
  logic                    o_busy;
  logic [DROP_CNT_W-1:0]   o_drop_cnt;

  modport master (
    input  i_opt, i_len, i_data, i_valid, m_ready,
    output m_data, m_valid, m_first, m_last, m_opt, o_busy, o_drop_cnt
  );

  modport slave (
    output i_opt, i_len, i_data, i_valid, m_ready,
    input  m_data, m_valid, m_first, m_last, m_opt, o_busy, o_drop_cnt
  );
endinterface

// File: rtl/uart_rx_frame_unpacker.sv
// Two-slot frame buffer replaying received UART frames as a valid/ready byte stream.
// Define UART_UNPACK_HDR_EN to prefix every frame with opt and len header beats.
module uart_rx_frame_unpacker #(
  parameter int BYTE_SIZE    = 8,
  parameter int MAX_MSG_LEN  = 255,
  parameter int DATA_BYTES   = $clog2(MAX_MSG_LEN),
  parameter int IN_DATA_SIZE = DATA_BYTES * BYTE_SIZE,
  parameter int DROP_CNT_W   = 8
) (
  input  logic CLK,
  input  logic RST,
  uart_rx_frame_unpacker_if.master bus
);
  localparam int CNT_W = $clog2(DATA_BYTES + 2);

`ifdef UART_UNPACK_HDR_EN
  typedef enum logic [1:0] {S_IDLE, S_HDR_OPT, S_HDR_LEN, S_DATA} state_t;
`else
  typedef enum logic {S_IDLE, S_DATA} state_t;
`endif

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        beat_q, beat_d;
  logic                    m_valid_q, m_valid_d;
  logic                    m_first_q, m_first_d;
  logic                    m_last_q, m_last_d;
  logic [BYTE_SIZE-1:0]    m_data_q, m_data_d;
  logic [BYTE_SIZE-1:0]    m_opt_q, m_opt_d;
  logic [DROP_CNT_W-1:0]   drop_cnt_q, drop_cnt_d;
  logic                    rd_ptr_q, rd_ptr_d;
  logic                    wr_ptr_q, wr_ptr_d;
  logic [1:0]              slot_full_q, slot_full_d;
  logic [BYTE_SIZE-1:0]    slot_opt_q [2];
  logic [BYTE_SIZE-1:0]    slot_opt_d [2];
  logic [BYTE_SIZE-1:0]    slot_len_q [2];
  logic [BYTE_SIZE-1:0]    slot_len_d [2];
  logic [IN_DATA_SIZE-1:0] slot_data_q [2];
  logic [IN_DATA_SIZE-1:0] slot_data_d [2];

  logic [CNT_W-1:0]        n_in, n_rd, n_src;
  logic [BYTE_SIZE-1:0]    src_opt;
  logic [IN_DATA_SIZE-1:0] src_data;
  logic                    storable, xfer, frame_done, wr_en;
  logic [1:0]              full_after_free;

  function automatic logic [CNT_W-1:0] clip_len(input logic [BYTE_SIZE-1:0] len);
    if (len > BYTE_SIZE'(DATA_BYTES)) return CNT_W'(DATA_BYTES);
    return CNT_W'(len);
  endfunction

  // Beat k of an n-byte payload; the newest byte sits in the low bits.
  function automatic logic [BYTE_SIZE-1:0] beat_byte(input logic [IN_DATA_SIZE-1:0] data,
                                                     input logic [CNT_W-1:0] n,
                                                     input logic [CNT_W-1:0] k);
    logic [CNT_W-1:0] pos;
    pos = n - k - 1'b1;
    return BYTE_SIZE'(data >> (int'(pos) * BYTE_SIZE));
  endfunction

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    m_valid_d   = m_valid_q;
    m_first_d   = m_first_q;
    m_last_d    = m_last_q;
    m_data_d    = m_data_q;
    m_opt_d     = m_opt_q;
    drop_cnt_d  = drop_cnt_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    slot_opt_d  = slot_opt_q;
    slot_len_d  = slot_len_q;
    slot_data_d = slot_data_q;

    n_in = clip_len(bus.i_len);
    n_rd = clip_len(slot_len_q[rd_ptr_q]);
`ifdef UART_UNPACK_HDR_EN
    storable = 1'b1;
`else
    storable = (n_in != '0);
`endif
    xfer       = m_valid_q && bus.m_ready;
    frame_done = xfer && m_last_q;

    // A slot freed by the last beat is writable in that same cycle.
    full_after_free = slot_full_q;
    if (frame_done) begin
      full_after_free[rd_ptr_q] = 1'b0;
      rd_ptr_d                  = ~rd_ptr_q;
    end
    wr_en       = bus.i_valid && storable && !full_after_free[wr_ptr_q];
    slot_full_d = full_after_free;
    if (wr_en) begin
      slot_opt_d[wr_ptr_q]  = bus.i_opt;
      slot_len_d[wr_ptr_q]  = bus.i_len;
      slot_data_d[wr_ptr_q] = bus.i_data;
      slot_full_d[wr_ptr_q] = 1'b1;
      wr_ptr_d              = ~wr_ptr_q;
    end
    if (bus.i_valid && storable && !wr_en && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + 1'b1;

    // With the read slot empty the buffer is empty, so wr_ptr == rd_ptr and the
    // frame arriving now is the one to start: bypass it for one-cycle latency.
    if (slot_full_q[rd_ptr_q]) begin
      src_opt  = slot_opt_q[rd_ptr_q];
      src_data = slot_data_q[rd_ptr_q];
      n_src    = n_rd;
    end else begin
      src_opt  = bus.i_opt;
      src_data = bus.i_data;
      n_src    = n_in;
    end

    case (state_q)
      S_IDLE: begin
        if (slot_full_q[rd_ptr_q] || wr_en) begin
          m_valid_d = 1'b1;
          m_first_d = 1'b1;
          m_opt_d   = src_opt;
          beat_d    = '0;
`ifdef UART_UNPACK_HDR_EN
          state_d   = S_HDR_OPT;
          m_data_d  = src_opt;
          m_last_d  = 1'b0;
`else
          state_d   = S_DATA;
          m_data_d  = beat_byte(src_data, n_src, '0);
          m_last_d  = (n_src == CNT_W'(1));
`endif
        end
      end
`ifdef UART_UNPACK_HDR_EN
      S_HDR_OPT: begin
        if (xfer) begin
          state_d   = S_HDR_LEN;
          m_data_d  = slot_len_q[rd_ptr_q];
          m_first_d = 1'b0;
          m_last_d  = (n_rd == '0);
        end
      end
      S_HDR_LEN: begin
        if (xfer) begin
          if (m_last_q) begin
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            state_d  = S_DATA;
            beat_d   = '0;
            m_data_d = beat_byte(slot_data_q[rd_ptr_q], n_rd, '0);
            m_last_d = (n_rd == CNT_W'(1));
          end
        end
      end
`endif
      S_DATA: begin
        if (xfer) begin
          m_first_d = 1'b0;
          if (m_last_q) begin
            state_d   = S_IDLE;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
          end else begin
            beat_d   = beat_q + 1'b1;
            m_data_d = beat_byte(slot_data_q[rd_ptr_q], n_rd, beat_d);
            m_last_d = (beat_d == n_rd - 1'b1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      beat_q      <= '0;
      m_valid_q   <= 1'b0;
      m_first_q   <= 1'b0;
      m_last_q    <= 1'b0;
      m_data_q    <= '0;
      m_opt_q     <= '0;
      drop_cnt_q  <= '0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      slot_full_q <= '0;
      slot_opt_q  <= '{default: '0};
      slot_len_q  <= '{default: '0};
      slot_data_q <= '{default: '0};
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      m_valid_q   <= m_valid_d;
      m_first_q   <= m_first_d;
      m_last_q    <= m_last_d;
      m_data_q    <= m_data_d;
      m_opt_q     <= m_opt_d;
      drop_cnt_q  <= drop_cnt_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      slot_full_q <= slot_full_d;
      slot_opt_q  <= slot_opt_d;
      slot_len_q  <= slot_len_d;
      slot_data_q <= slot_data_d;
    end
  end

  assign bus.m_data     = m_data_q;
  assign bus.m_valid    = m_valid_q;
  assign bus.m_first    = m_first_q;
  assign bus.m_last     = m_last_q;
  assign bus.m_opt      = m_opt_q;
  assign bus.o_busy     = |slot_full_q;
  assign bus.o_drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_frame_unpacker.sv
// Self-checking bench for uart_rx_frame_unpacker: vector table, corner sequences,
// and random traffic against a frame-level reference model.
module tb_uart_rx_frame_unpacker;
  logic CLK = 1'b0;
  logic RST;

  uart_rx_frame_unpacker_if bus ();
  uart_rx_frame_unpacker dut (.CLK(CLK), .RST(RST), .bus(bus));

  always #5 CLK = ~CLK;

`ifdef UART_UNPACK_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       first;
    logic       last;
    logic [7:0] opt;
  } beat_t;

  typedef struct {
    logic [7:0]  opt;
    logic [7:0]  len;
    logic [63:0] data;
    int          n;
    logic [63:0] seq;   // expected payload beats, beat 0 in [63:56]
  } vec_t;

  beat_t       exp_q[$];
  int          frm_q[$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          exp_drop = 0;
  vec_t        vecs[7];
  beat_t       b;
  logic [63:0] s;
  logic [7:0]  ropt, rlen, pd;
  logic [63:0] rdata;
  logic        stall_prev, plast, xf, injected, storable;
  int          nb, cyc, got, r;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [7:0] sat_drop();
    return (exp_drop > 255) ? 8'hFF : 8'(exp_drop);
  endfunction

  // Model: optional header {opt,len}, then the newest min(len,8) bytes, oldest first.
  task automatic push_frame(input logic [7:0] opt, input logic [7:0] len,
                            input logic [63:0] data, output int nbeats);
    logic [7:0] bq[$];
    logic [7:0] stored[8];
    int         n;
    n = (len > 8'd8) ? 8 : int'(len);
    for (int i = 0; i < 8; i++) stored[i] = data[63 - 8*i -: 8];
    if (HDR) begin
      bq.push_back(opt);
      bq.push_back(len);
    end
    for (int i = 8 - n; i < 8; i++) bq.push_back(stored[i]);
    for (int k = 0; k < bq.size(); k++)
      exp_q.push_back('{data: bq[k], first: (k == 0), last: (k == bq.size() - 1), opt: opt});
    nbeats = bq.size();
  endtask

  task automatic send(input logic [7:0] opt, input logic [7:0] len, input logic [63:0] data);
    bus.i_opt   = opt;
    bus.i_len   = len;
    bus.i_data  = data;
    bus.i_valid = 1'b1;
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic check_beat(input string tag, input beat_t e);
    check({tag, "_data"},  bus.m_data,  e.data);
    check({tag, "_first"}, bus.m_first, e.first);
    check({tag, "_last"},  bus.m_last,  e.last);
    check({tag, "_opt"},   bus.m_opt,   e.opt);
  endtask

  task automatic run_expect(input string tag, input int budget);
    beat_t e;
    int    c;
    c = 0;
    while (exp_q.size() > 0 && c < budget) begin
      if (bus.m_valid && bus.m_ready) begin
        e = exp_q.pop_front();
        check_beat(tag, e);
      end
      tick();
      c++;
    end
    check({tag, "_beats_left"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
    $fatal(1);
  end

  initial begin
    RST = 1'b1;
    bus.i_opt = '0; bus.i_len = '0; bus.i_data = '0; bus.i_valid = 1'b0; bus.m_ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_first", bus.m_first, 0);
    check("rst_m_last",  bus.m_last, 0);
    check("rst_m_data",  bus.m_data, 0);
    check("rst_m_opt",   bus.m_opt, 0);
    check("rst_busy",    bus.o_busy, 0);
    check("rst_drop",    bus.o_drop_cnt, 0);
    RST = 1'b0;
    tick();

    // ---- vector table, consumer always ready ----
    vecs[0] = '{opt: 8'h11, len: 8'd3,   data: 64'h0000_0000_00A1_B2C3, n: 3, seq: 64'hA1B2_C300_0000_0000};
    vecs[1] = '{opt: 8'h22, len: 8'd10,  data: 64'h0102_0304_0506_0708, n: 8, seq: 64'h0102_0304_0506_0708};
    vecs[2] = '{opt: 8'h33, len: 8'd1,   data: 64'h0000_0000_0000_FF7E, n: 1, seq: 64'h7E00_0000_0000_0000};
    vecs[3] = '{opt: 8'h44, len: 8'd8,   data: 64'h8899_AABB_CCDD_EEFF, n: 8, seq: 64'h8899_AABB_CCDD_EEFF};
    vecs[4] = '{opt: 8'h55, len: 8'd255, data: 64'h1122_3344_5566_7788, n: 8, seq: 64'h1122_3344_5566_7788};
    vecs[5] = '{opt: 8'h66, len: 8'd2,   data: 64'h0000_DEAD_0000_BEEF, n: 2, seq: 64'hBEEF_0000_0000_0000};
    vecs[6] = '{opt: 8'h77, len: 8'd5,   data: 64'hFFFF_FF0A_0B0C_0D0E, n: 5, seq: 64'h0A0B_0C0D_0E00_0000};
    bus.m_ready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      exp_q.delete();
      if (HDR) begin
        exp_q.push_back('{data: vecs[v].opt, first: 1'b1, last: 1'b0, opt: vecs[v].opt});
        exp_q.push_back('{data: vecs[v].len, first: 1'b0, last: (vecs[v].n == 0), opt: vecs[v].opt});
      end
      for (int k = 0; k < vecs[v].n; k++) begin
        s = vecs[v].seq << (8 * k);
        exp_q.push_back('{data: s[63:56], first: (k == 0) && !HDR, last: (k == vecs[v].n - 1), opt: vecs[v].opt});
      end
      send(vecs[v].opt, vecs[v].len, vecs[v].data);
      check($sformatf("vec%0d_latency_valid", v), bus.m_valid, 1);
      check($sformatf("vec%0d_latency_first", v), bus.m_first, 1);
      run_expect($sformatf("vec%0d", v), 30);
    end
    check("table_drop", bus.o_drop_cnt, sat_drop());

    // ---- backpressure mid-frame ----
    push_frame(8'h3C, 8'd8, 64'h0102_0304_0506_0708, nb);
    send(8'h3C, 8'd8, 64'h0102_0304_0506_0708);
    got = 0; cyc = 0;
    while (got < 3 && cyc < 20) begin
      if (bus.m_valid) begin
        b = exp_q.pop_front();
        check_beat("stall_pre", b);
        got++;
      end
      tick();
      cyc++;
    end
    bus.m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("stall_valid", bus.m_valid, 1);
      check("stall_data", bus.m_data, exp_q[0].data);
      tick();
    end
    bus.m_ready = 1'b1;
    run_expect("stall_resume", 30);

    // ---- three back-to-back frames while stalled: third dropped ----
    bus.m_ready = 1'b0;
    push_frame(8'hA1, 8'd3, 64'h0000_0000_0010_2030, nb);
    send(8'hA1, 8'd3, 64'h0000_0000_0010_2030);
    push_frame(8'hA2, 8'd2, 64'h0000_0000_0000_4050, nb);
    send(8'hA2, 8'd2, 64'h0000_0000_0000_4050);
    send(8'hA3, 8'd4, 64'h0000_0000_6070_8090);
    exp_drop++;
    check("full_busy", bus.o_busy, 1);
    check("full_drop", bus.o_drop_cnt, sat_drop());
    bus.m_ready = 1'b1;
    run_expect("full_stream", 60);
    repeat (3) tick();
    check("full_after_valid", bus.m_valid, 0);
    check("full_after_busy", bus.o_busy, 0);

    // ---- new frame in the cycle the final beat frees a slot ----
    bus.m_ready = 1'b0;
    push_frame(8'hB0, 8'd2, 64'h0000_0000_0000_C1C2, nb);
    send(8'hB0, 8'd2, 64'h0000_0000_0000_C1C2);
    push_frame(8'hB1, 8'd1, 64'h0000_0000_0000_00D1, nb);
    send(8'hB1, 8'd1, 64'h0000_0000_0000_00D1);
    push_frame(8'hB2, 8'd3, 64'h0000_0000_00E1_E2E3, nb);
    bus.m_ready = 1'b1;
    injected = 1'b0; cyc = 0;
    while (exp_q.size() > 0 && cyc < 60) begin
      bus.i_valid = 1'b0;
      if (bus.m_valid) begin
        b = exp_q.pop_front();
        check_beat("free_race", b);
        if (b.last && !injected) begin
          injected    = 1'b1;
          bus.i_opt   = 8'hB2;
          bus.i_len   = 8'd3;
          bus.i_data  = 64'h0000_0000_00E1_E2E3;
          bus.i_valid = 1'b1;
        end
      end
      tick();
      cyc++;
    end
    bus.i_valid = 1'b0;
    check("free_race_beats_left", exp_q.size(), 0);
    exp_q.delete();
    check("free_race_drop", bus.o_drop_cnt, sat_drop());

    // ---- len == 0 frame ----
    push_frame(8'h5A, 8'd0, 64'h0, nb);
    send(8'h5A, 8'd0, 64'h0);
`ifdef UART_UNPACK_HDR_EN
    check("len0_busy", bus.o_busy, 1);
`else
    check("len0_busy", bus.o_busy, 0);
`endif
    run_expect("len0", 10);
    repeat (3) tick();
    check("len0_valid_after", bus.m_valid, 0);
    check("len0_busy_after", bus.o_busy, 0);
    check("len0_drop", bus.o_drop_cnt, sat_drop());

    // ---- random traffic against the model ----
    stall_prev = 1'b0; pd = '0; plast = 1'b0;
    for (int c = 0; c < 400; c++) begin
      r = $urandom_range(0, 9);
      rlen  = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(9, 255)) : 8'($urandom_range(1, 8));
      ropt  = 8'($urandom);
      rdata = {$urandom, $urandom};
      bus.i_opt   = ropt;
      bus.i_len   = rlen;
      bus.i_data  = rdata;
      bus.i_valid = ($urandom_range(0, 3) == 0);
      bus.m_ready = ($urandom_range(0, 9) < 7);
      if (frm_q.size() == 0) check("rnd_idle_valid", bus.m_valid, 0);
      if (stall_prev) begin
        check("rnd_hold_valid", bus.m_valid, 1);
        check("rnd_hold_data", bus.m_data, pd);
        check("rnd_hold_last", bus.m_last, plast);
      end
      xf = bus.m_valid && bus.m_ready;
      if (xf) begin
        if (exp_q.size() == 0) check("rnd_extra_beat", bus.m_valid, 0);
        else begin
          b = exp_q.pop_front();
          check_beat("rnd", b);
          frm_q[0] = frm_q[0] - 1;
          if (frm_q[0] == 0) void'(frm_q.pop_front());
        end
      end
      if (bus.i_valid) begin
        storable = HDR || (rlen != 8'd0);
        if (storable) begin
          if (frm_q.size() < 2) begin
            push_frame(ropt, rlen, rdata, nb);
            frm_q.push_back(nb);
          end else exp_drop++;
        end
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      pd         = bus.m_data;
      plast      = bus.m_last;
      tick();
      check("rnd_busy", bus.o_busy, frm_q.size() > 0);
      check("rnd_drop", bus.o_drop_cnt, sat_drop());
    end
    bus.i_valid = 1'b0;
    bus.m_ready = 1'b1;
    run_expect("rnd_drain", 300);
    frm_q.delete();
    check("rnd_drain_busy", bus.o_busy, 0);

    // ---- drop counter saturation ----
    bus.m_ready = 1'b0;
    push_frame(8'hC0, 8'd2, 64'h0000_0000_0000_0A0B, nb);
    send(8'hC0, 8'd2, 64'h0000_0000_0000_0A0B);
    push_frame(8'hC1, 8'd1, 64'h0000_0000_0000_000C, nb);
    send(8'hC1, 8'd1, 64'h0000_0000_0000_000C);
    for (int i = 0; i < 260; i++) begin
      send(8'hCC, 8'd4, 64'hDEAD_BEEF);
      exp_drop++;
    end
    check("sat_drop", bus.o_drop_cnt, sat_drop());
    bus.m_ready = 1'b1;
    run_expect("sat_stream", 40);

    // ---- asynchronous reset mid-stream ----
    bus.m_ready = 1'b0;
    send(8'hE0, 8'd4, 64'h0000_0000_1122_3344);
    send(8'hE1, 8'd4, 64'h0000_0000_5566_7788);
    check("prerst_valid", bus.m_valid, 1);
    #2 RST = 1'b1;
    #1;
    check("arst_valid", bus.m_valid, 0);
    check("arst_busy", bus.o_busy, 0);
    check("arst_drop", bus.o_drop_cnt, 0);
    #2 RST = 1'b0;
    tick();
    exp_drop = 0;
    bus.m_ready = 1'b1;
    push_frame(8'hF0, 8'd2, 64'h0000_0000_0000_9A9B, nb);
    send(8'hF0, 8'd2, 64'h0000_0000_0000_9A9B);
    run_expect("post_rst", 20);
    check("post_rst_busy", bus.o_busy, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
